// File: rtl/core_if_ifu.sv
// Fetch stage: single-outstanding imem requests, static BTFN/JAL next-PC prediction, valid/ready output register.
// Latency: request in cycle N, response N+1, valid_out N+2; a request issues only when the output slot is free or draining.
module core_if_ifu #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    output logic [PC_W-1:0]   ifu_req_addr,
    input  logic              ifu_rsp_valid,
    input  logic [INST_W-1:0] ifu_rsp_inst,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [PC_W-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_branch_predict
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     req_pc_q;
    logic                valid_out_q;
    logic [PC_W-1:0]     o_pc_q;
    logic [INST_W-1:0]   o_inst_q;
    logic                o_bp_q;

    logic                pred_d;
    logic [PC_W-1:0]     imm_d;
    logic [PC_W-1:0]     next_pc_d;

    // Static prediction: JAL always taken, conditional branches taken only when backward.
    always_comb begin
        pred_d = 1'b0;
        imm_d  = '0;
        case (ifu_rsp_inst[6:0])
            7'b1101111: begin
                pred_d = 1'b1;
                imm_d  = {{(PC_W-21){ifu_rsp_inst[31]}}, ifu_rsp_inst[31], ifu_rsp_inst[19:12],
                          ifu_rsp_inst[20], ifu_rsp_inst[30:21], 1'b0};
            end
            7'b1100011: begin
                pred_d = ifu_rsp_inst[31];
                imm_d  = {{(PC_W-13){ifu_rsp_inst[31]}}, ifu_rsp_inst[31], ifu_rsp_inst[7],
                          ifu_rsp_inst[30:25], ifu_rsp_inst[11:8], 1'b0};
            end
            default: begin
                pred_d = 1'b0;
                imm_d  = '0;
            end
        endcase
        next_pc_d = req_pc_q + (pred_d ? imm_d : PC_W'(4));
    end

    assign ifu_req_valid = rst_n && (state_q == S_REQ) && !flush_req && (!valid_out_q || ready_out);
    assign ifu_req_addr  = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            valid_out_q <= 1'b0;
            o_pc_q      <= '0;
            o_inst_q    <= INST_W'(32'h0000_0013);
            o_bp_q      <= 1'b0;
        end else if (flush_req) begin
            pc_q        <= flush_pc;
            valid_out_q <= 1'b0;
            // A request still in flight must have its response swallowed.
            case (state_q)
                S_WAIT:  state_q <= ifu_rsp_valid ? S_REQ : S_DROP;
                S_DROP:  state_q <= ifu_rsp_valid ? S_REQ : S_DROP;
                default: state_q <= S_REQ;
            endcase
        end else begin
            if (valid_out_q && ready_out) begin
                valid_out_q <= 1'b0;
            end
            case (state_q)
                S_REQ: begin
                    if (ifu_req_valid && ifu_req_ready) begin
                        req_pc_q <= pc_q;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ifu_rsp_valid) begin
                        o_pc_q      <= req_pc_q;
                        o_inst_q    <= ifu_rsp_inst;
                        o_bp_q      <= pred_d;
                        valid_out_q <= 1'b1;
                        pc_q        <= next_pc_d;
                        state_q     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (ifu_rsp_valid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign valid_out        = valid_out_q;
    assign o_pc             = o_pc_q;
    assign o_inst           = o_inst_q;
    assign o_branch_predict = o_bp_q;

endmodule

// File: tb/tb_core_if_ifu.sv
// Bench for core_if_ifu: directed prediction vectors, flush/stall sequences, and a randomized program walk.
module tb_core_if_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_branch_predict;

    core_if_ifu #(.PC_W(32), .INST_W(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_pc(flush_pc),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
        .valid_out(valid_out), .ready_out(ready_out), .o_pc(o_pc), .o_inst(o_inst),
        .o_branch_predict(o_branch_predict)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: synthetic program image, a pure function of the address.
    function automatic logic [31:0] inst_for(input logic [31:0] pc);
        logic [2:0] sel;
        sel = pc[4:2] ^ pc[9:7];
        case (sel)
            3'd0: return 32'h0000_0013;
            3'd1: return 32'h0080_006F;
            3'd2: return 32'hFE00_08E3;
            3'd3: return 32'h0000_0863;
            3'd4: return 32'h0000_80E7;
            3'd5: return 32'hFF9F_F06F;
            3'd6: return 32'h8000_00B7;
            default: return 32'h0010_0093;
        endcase
    endfunction

    function automatic logic model_pred(input logic [31:0] i);
        if (i[6:0] == 7'h6F) return 1'b1;
        if (i[6:0] == 7'h63) return i[31];
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] i);
        logic [31:0] off;
        off = 32'd4;
        if (i[6:0] == 7'h6F) begin
            off = 32'(i[30:21]) * 32'd2 + 32'(i[20]) * 32'd2048 + 32'(i[19:12]) * 32'd4096
                  - 32'(i[31]) * 32'h0010_0000;
        end else if (i[6:0] == 7'h63 && i[31]) begin
            off = 32'(i[11:8]) * 32'd2 + 32'(i[30:25]) * 32'd32 + 32'(i[7]) * 32'd2048 - 32'd4096;
        end
        return pc + off;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
        logic [31:0] nxt;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v, input int idx);
        flush_req = 1'b1; flush_pc = v.pc; ready_out = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0; ifu_req_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_req_vld", idx), 32'(ifu_req_valid), 32'd1);
        chk($sformatf("v%0d_req_addr", idx), ifu_req_addr, v.pc);
        @(posedge clk); #1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = v.inst;
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_vld", idx), 32'(valid_out), 32'd1);
        chk($sformatf("v%0d_pc", idx), o_pc, v.pc);
        chk($sformatf("v%0d_inst", idx), o_inst, v.inst);
        chk($sformatf("v%0d_pred", idx), 32'(o_branch_predict), 32'(v.pred));
        chk($sformatf("v%0d_next", idx), ifu_req_addr, v.nxt);
    endtask

    logic [31:0] exp_pc, pend_addr, prev_pc, prev_inst;
    logic        pend, hold;
    int          wt, n_out;

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h0000_0013, 1'b0, 32'h8000_0004};
        vecs[1] = '{32'h8000_0010, 32'hFE00_08E3, 1'b1, 32'h8000_0000};
        vecs[2] = '{32'h8000_0000, 32'h0080_006F, 1'b1, 32'h8000_0008};
        vecs[3] = '{32'h8000_0020, 32'h0000_0863, 1'b0, 32'h8000_0024};
        vecs[4] = '{32'h8000_0030, 32'h0000_80E7, 1'b0, 32'h8000_0034};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'h0000_0004, 32'hFF9F_F06F, 1'b1, 32'hFFFF_FFFC};
        vecs[7] = '{32'h8000_0100, 32'hFE10_1EE3, 1'b1, 32'h8000_00FC};
        vecs[8] = '{32'h8000_0200, 32'h8000_00B7, 1'b0, 32'h8000_0204};

        rst_n = 1'b0; flush_req = 1'b0; flush_pc = '0; ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0; ifu_rsp_inst = '0; ready_out = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_vld", 32'(ifu_req_valid), 32'd0);
        chk("rst_vld", 32'(valid_out), 32'd0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_inst", o_inst, 32'h0000_0013);
        chk("rst_pred", 32'(o_branch_predict), 32'd0);
        rst_n = 1'b1; ifu_req_ready = 1'b1;
        #1;
        chk("first_req_vld", 32'(ifu_req_valid), 32'd1);
        chk("first_req_addr", ifu_req_addr, 32'h8000_0000);
        @(posedge clk); #1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0000_0013;
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0;
        @(negedge clk);
        chk("first_vld", 32'(valid_out), 32'd1);
        chk("first_pc", o_pc, 32'h8000_0000);
        chk("first_pred", 32'(o_branch_predict), 32'd0);
        chk("first_next", ifu_req_addr, 32'h8000_0004);

        for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

        // Flush while waiting; response arrives later and must be discarded.
        ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0; flush_req = 1'b1; flush_pc = 32'h8000_0100;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0080_006F;
        @(negedge clk);
        chk("drop_noreq", 32'(ifu_req_valid), 32'd0);
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0;
        @(negedge clk);
        chk("drop_vld", 32'(valid_out), 32'd0);
        chk("drop_req_vld", 32'(ifu_req_valid), 32'd1);
        chk("drop_req_addr", ifu_req_addr, 32'h8000_0100);

        // Flush coincident with the response.
        ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0000_0013;
        flush_req = 1'b1; flush_pc = 32'h8000_0200;
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0; flush_req = 1'b0;
        @(negedge clk);
        chk("coinc_vld", 32'(valid_out), 32'd0);
        chk("coinc_req_vld", 32'(ifu_req_valid), 32'd1);
        chk("coinc_req_addr", ifu_req_addr, 32'h8000_0200);
        ifu_req_ready = 1'b1;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0000_0013;
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0;
        @(negedge clk);
        chk("coinc_after_vld", 32'(valid_out), 32'd1);
        chk("coinc_after_pc", o_pc, 32'h8000_0200);

        // Decode stall for 5 cycles, then release.
        ready_out = 1'b0; ifu_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stall%0d_vld", c), 32'(valid_out), 32'd1);
            chk($sformatf("stall%0d_pc", c), o_pc, 32'h8000_0200);
            chk($sformatf("stall%0d_inst", c), o_inst, 32'h0000_0013);
            chk($sformatf("stall%0d_noreq", c), 32'(ifu_req_valid), 32'd0);
        end
        ready_out = 1'b1;
        #1;
        chk("release_req_vld", 32'(ifu_req_valid), 32'd1);
        chk("release_req_addr", ifu_req_addr, 32'h8000_0204);
        @(posedge clk); #1;
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0010_0093;
        @(negedge clk);
        chk("release_drained", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0;
        @(negedge clk);
        chk("release_vld", 32'(valid_out), 32'd1);
        chk("release_pc", o_pc, 32'h8000_0204);
        chk("release_inst", o_inst, 32'h0010_0093);

        // Randomized walk of the synthetic program with random stalls, latencies and flushes.
        rst_n = 1'b0; flush_req = 1'b0; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ready_out = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h8000_0000; pend = 1'b0; hold = 1'b0; wt = 0; n_out = 0;
        pend_addr = '0; prev_pc = '0; prev_inst = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            ready_out     = ($urandom_range(0, 3) != 0);
            ifu_req_ready = ($urandom_range(0, 2) != 0);
            flush_req     = ($urandom_range(0, 39) == 0);
            flush_pc      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2)
                                                        : 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            if (pend && wt == 0) begin
                ifu_rsp_valid = 1'b1;
                ifu_rsp_inst  = inst_for(pend_addr);
            end else begin
                ifu_rsp_valid = 1'b0;
                ifu_rsp_inst  = $urandom;
                if (pend) wt--;
            end
            @(negedge clk);
            if (hold) begin
                chk("rnd_hold_vld", 32'(valid_out), 32'd1);
                chk("rnd_hold_pc", o_pc, prev_pc);
                chk("rnd_hold_inst", o_inst, prev_inst);
            end
            hold = valid_out && !ready_out && !flush_req;
            prev_pc = o_pc; prev_inst = o_inst;
            if (ifu_rsp_valid) pend = 1'b0;
            if (flush_req) begin
                chk("rnd_flush_noreq", 32'(ifu_req_valid), 32'd0);
                exp_pc = flush_pc;
            end else if (valid_out && ready_out) begin
                chk("rnd_pc", o_pc, exp_pc);
                chk("rnd_inst", o_inst, inst_for(exp_pc));
                chk("rnd_pred", 32'(o_branch_predict), 32'(model_pred(inst_for(exp_pc))));
                exp_pc = model_next(exp_pc, inst_for(exp_pc));
                n_out++;
            end
            if (ifu_req_valid && ifu_req_ready) begin
                chk("rnd_single_outstanding", 32'(pend), 32'd0);
                pend = 1'b1;
                wt = $urandom_range(0, 2);
                pend_addr = ifu_req_addr;
            end
        end
        chk("rnd_outputs_seen", 32'(n_out >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/core_if_ifu.md
Name: core_if_ifu

Overview:
Instruction fetch stage at the head of the pipeline. It holds the fetch PC, issues single-outstanding requests to instruction memory, and applies static BTFN/JAL prediction to choose the next PC. It presents {pc, inst, branch_predict} to decode through a valid/ready output register. It redirects on the commit-stage flush from the execute stage, `cmt_pipeline_flush_req` / `cmt_flush_pc`.

Parameters:
PC_W, 32, fetch PC width; equals CORE_PC_WIDTH.
INST_W, 32, instruction width.
RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
flush_req  in  1  pipeline flush from the commit stage
flush_pc  in  PC_W  redirect target, valid while flush_req=1
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  memory accepts the request
ifu_req_addr  out  PC_W  fetch address; equals the pc register
ifu_rsp_valid  in  1  response valid; always accepted, no ready signal
ifu_rsp_inst  in  INST_W  fetched instruction
valid_out  out  1  output register holds an instruction
ready_out  in  1  decode accepts the output
o_pc  out  PC_W  PC of the output instruction
o_inst  out  INST_W  output instruction
o_branch_predict  out  1  1 = predicted taken

Behaviour:
Clock and reset:
- Single clock `clk`. Asynchronous active-low reset `rst_n`, as already decided.
- Reset values: pc=RESET_PC; state=REQ; valid_out=0; o_pc=0; o_inst=32'h0000_0013 (NOP); o_branch_predict=0; kill flag=0.
- ifu_req_valid is combinational and is 0 while rst_n=0.

State machine (3 states):
- REQ:
  - ifu_req_valid = ~flush_req & (~valid_out | ready_out).
  - On ifu_req_valid & ifu_req_ready: capture req_pc=pc; go to WAIT.
- WAIT, on ifu_rsp_valid:
  - Load output register: o_pc=req_pc, o_inst=ifu_rsp_inst, o_branch_predict=pred; valid_out=1.
  - pc <= pred ? req_pc+imm : req_pc+4.
  - Go to REQ.
- DROP (response owed to a flushed request), on ifu_rsp_valid: discard the response; go to REQ. pc is not touched.

Handshakes and latency:
- At most one request is outstanding.
- Minimum latency: request accepted in cycle N, response in cycle N+1, valid_out in cycle N+2.
- The next request may issue in the same cycle valid_out & ready_out drains the output register.
- Output: valid_out & ready_out with no new load → valid_out <= 0. Output data holds stable while valid_out & ~ready_out.
- ifu_req_addr/valid are held stable until ready.

Prediction (combinational on ifu_rsp_inst; arithmetic modulo 2^PC_W):
- opcode 1101111 (JAL): pred=1. imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- opcode 1100011 (branch): pred = inst[31]. imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
- All others, including JALR: pred=0.

Flush (highest priority, any state):
- pc <= flush_pc; valid_out <= 0.
- No request issues in a flush cycle.
- In WAIT without ifu_rsp_valid the same cycle: go to DROP.
- In WAIT or DROP with ifu_rsp_valid the same cycle: discard the response; go to REQ.
- In REQ: stay in REQ.
- Flush overrides a coincident output handshake; the decoder ignores the data.

Wrap-around: pc+4 and pc+imm wrap silently; no alignment check is performed.

Test Plan:
- Reset release with ready=1 and 1-cycle memory → first ifu_req_addr=0x8000_0000. NOP response → valid_out with o_pc=0x8000_0000, o_branch_predict=0; next request 0x8000_0004.
- Response 0xFE0008E3 (beq -16) at pc 0x8000_0010 → o_branch_predict=1; next ifu_req_addr=0x8000_0000.
- Response 0x0080006F (jal +8) at pc 0x8000_0000 → predict=1; next addr 0x8000_0008. Forward beq 0x00000863 → predict=0; next addr pc+4.
- flush_req with flush_pc=0x8000_0100 while in WAIT, response arriving 3 cycles later → response dropped, valid_out stays 0; next request 0x8000_0100.
- flush_req in the same cycle as ifu_rsp_valid → no output load; next request at flush_pc.
- ready_out=0 for 5 cycles with valid_out=1 → o_pc/o_inst stable and ifu_req_valid=0. On ready_out=1 the request issues that cycle; no instruction is lost or duplicated.
